alloc_arbiter: RTL

- Upstream front-end for the linked-memory allocator.
- Accepts heap requests (ALLOC, FREE, READ, WRITE) from two independent clients using valid/ready handshakes.
- Serialises them round-robin into the allocator's single-request-per-cycle interface and routes each one-cycle-later result back to the originating client.
- Pre-checks pointer tags, and halts both clients when the allocator or the arbiter itself signals an error.

---
 rtl/alloc_pkg.sv | 40 ++++
 rtl/alloc_arbiter_if.sv | 23 ++
 rtl/alloc_arbiter_rr_arb2.sv | 31 +++
 rtl/alloc_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alloc_pkg.sv
// Shared opcodes, pointer tag masks, heap constants and pipeline types for the
// allocator front-end.
package alloc_pkg;

   typedef enum logic [1:0] {
      OP_ALLOC = 2'd0,
      OP_FREE  = 2'd1,
      OP_READ  = 2'd2,
      OP_WRITE = 2'd3
   } op_e;

   localparam logic [15:0] DIR_TAG = 16'h8000;
   localparam logic [15:0] MUT_TAG = 16'h4000;
   localparam logic [15:0] OPQ_TAG = 16'h2000;
   localparam logic [15:0] VLT_TAG = 16'h1000;

   localparam logic [15:0] UNDEF = 16'h0000;
   localparam logic [15:0] NIL   = 16'h0001;
   localparam logic [15:0] FALSE = 16'h0002;
   localparam logic [15:0] TRUE  = 16'h0003;
   localparam logic [15:0] UNIT  = 16'h0004;
   localparam logic [15:0] ZERO  = DIR_TAG;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   typedef struct packed {
      logic valid;
      logic client;
      op_e  op;
   } stag_t;

   // Only mutable heap cells may be freed, read or written.
   function automatic logic ptr_ok(input op_e op, input logic [15:0] addr);
      return (op == OP_ALLOC) || ((addr & MUT_TAG) != 16'h0000);
   endfunction

endpackage

// File: rtl/alloc_arbiter_if.sv
// One client's request/response bundle; master is the client, slave the arbiter.
interface alloc_arbiter_if #(
   parameter int unsigned DATA_SZ = 16,
   parameter int unsigned OP_SZ   = 2
);
   logic               req_valid;
   logic [OP_SZ-1:0]   req_op;
   logic [DATA_SZ-1:0] req_addr;
   logic [DATA_SZ-1:0] req_data;
   logic               req_ready;
   logic               rsp_valid;
   logic [DATA_SZ-1:0] rsp_data;

   modport master (
      output req_valid, req_op, req_addr, req_data,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_data,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/alloc_arbiter_rr_arb2.sv
// Two-way round-robin grant; on a tie the client that did not win last time
// is granted.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);
   logic r_last;

   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= 1'b1;
      end else if (o_gnt != 2'b00) begin
         r_last <= o_gnt[1];
      end
   end
endmodule

// File: rtl/alloc_arbiter.sv
// Two-client front-end for the linked-memory allocator: round-robin serialise,
// tag pre-check, two-stage tag pipeline for response routing, sticky halt.
module alloc_arbiter
   import alloc_pkg::*;
#(
   parameter int unsigned DATA_SZ = 16,
   parameter int unsigned OP_SZ   = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   alloc_arbiter_if.slave     io_c0,
   alloc_arbiter_if.slave     io_c1,
   output logic               o_mem_alloc,
   output logic [DATA_SZ-1:0] o_mem_data,
   output logic               o_mem_free,
   output logic [DATA_SZ-1:0] o_mem_addr,
   output logic               o_mem_wr,
   output logic [DATA_SZ-1:0] o_mem_waddr,
   output logic [DATA_SZ-1:0] o_mem_wdata,
   output logic               o_mem_rd,
   output logic [DATA_SZ-1:0] o_mem_raddr,
   input  logic [DATA_SZ-1:0] i_mem_addr,
   input  logic [DATA_SZ-1:0] i_mem_rdata,
   input  logic               i_mem_err,
   output logic               o_err
);
   logic [1:0]         w_gnt;
   logic               w_run, w_sel, w_bad, w_fwd;
   logic [OP_SZ-1:0]   w_op_raw;
   op_e                w_op;
   logic [DATA_SZ-1:0] w_addr, w_data, w_rsp_data;
   state_e             r_state, w_state_d;
   stag_t              r_s1, r_s2, w_s1_d, w_s2_d;
   logic [DATA_SZ-1:0] r_mem_data, r_mem_addr, r_mem_waddr, r_mem_wdata, r_mem_raddr;

   // Gating with i_rst_n keeps ready low for the whole reset cycle.
   assign w_run = (r_state == ST_RUN) && i_rst_n;

   rr_arb2 u_rr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_run),
      .i_req   ({io_c1.req_valid, io_c0.req_valid}),
      .o_gnt   (w_gnt)
   );

   assign io_c0.req_ready = w_gnt[0];
   assign io_c1.req_ready = w_gnt[1];

   always_comb begin
      w_sel     = w_gnt[1];
      w_op_raw  = w_sel ? io_c1.req_op   : io_c0.req_op;
      w_addr    = w_sel ? io_c1.req_addr : io_c0.req_addr;
      w_data    = w_sel ? io_c1.req_data : io_c0.req_data;
      w_op      = op_e'(w_op_raw);
      w_bad     = (w_gnt != 2'b00) && !ptr_ok(w_op, w_addr);
      w_fwd     = (w_gnt != 2'b00) && !w_bad;
      w_state_d = r_state;
      if ((r_state == ST_RUN) && (i_mem_err || w_bad)) begin
         w_state_d = ST_HALT;
      end
      // Entering or sitting in HALT drops every in-flight tag.
      w_s1_d        = '{valid: w_fwd && (w_state_d == ST_RUN), client: w_sel, op: w_op};
      w_s2_d        = r_s1;
      w_s2_d.valid  = r_s1.valid && (w_state_d == ST_RUN);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_RUN;
         r_s1        <= '{valid: 1'b0, client: 1'b0, op: OP_ALLOC};
         r_s2        <= '{valid: 1'b0, client: 1'b0, op: OP_ALLOC};
         r_mem_data  <= UNDEF;
         r_mem_addr  <= UNDEF;
         r_mem_waddr <= UNDEF;
         r_mem_wdata <= UNDEF;
         r_mem_raddr <= UNDEF;
      end else begin
         r_state <= w_state_d;
         r_s1    <= w_s1_d;
         r_s2    <= w_s2_d;
         if (w_fwd) begin
            case (w_op)
               OP_ALLOC: r_mem_data  <= w_data;
               OP_FREE:  r_mem_addr  <= w_addr;
               OP_READ:  r_mem_raddr <= w_addr;
               OP_WRITE: begin
                  r_mem_waddr <= w_addr;
                  r_mem_wdata <= w_data;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_mem_alloc = r_s1.valid && (r_s1.op == OP_ALLOC);
   assign o_mem_free  = r_s1.valid && (r_s1.op == OP_FREE);
   assign o_mem_rd    = r_s1.valid && (r_s1.op == OP_READ);
   assign o_mem_wr    = r_s1.valid && (r_s1.op == OP_WRITE);
   assign o_mem_data  = r_mem_data;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_waddr = r_mem_waddr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_raddr = r_mem_raddr;
   assign o_err       = (r_state == ST_HALT);

   always_comb begin
      case (r_s2.op)
         OP_ALLOC: w_rsp_data = i_mem_addr;
         OP_READ:  w_rsp_data = i_mem_rdata;
         default:  w_rsp_data = UNDEF;
      endcase
   end

   assign io_c0.rsp_valid = r_s2.valid && !r_s2.client;
   assign io_c1.rsp_valid = r_s2.valid && r_s2.client;
   assign io_c0.rsp_data  = io_c0.rsp_valid ? w_rsp_data : UNDEF;
   assign io_c1.rsp_data  = io_c1.rsp_valid ? w_rsp_data : UNDEF;
endmodule
